// File: rtl/issue_scoreboard.sv
// Issue hazard controller for the in-order pipeline: tracks in-flight register writes
// in a shift-register scoreboard, stalls on RAW hazards and squashes entries on redirect.
module issue_scoreboard #(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b0,
    parameter int CNT_W     = 32,
    parameter int KW        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_use1,
    input  logic             issue_use2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_werf,
    input  logic             kill_valid,
    input  logic [KW-1:0]    kill_count,
    output logic             issue_ready,
    output logic             issue_fire,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    // With a write-then-read regfile the writeback entry cannot cause a hazard.
    localparam int NCHK = WB_BYPASS ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0] sb_v;
    logic [4:0]       sb_rd [DEPTH];
    logic [DEPTH-1:0] kill_mask;
    logic             hazard;
    logic             stall_evt;
    logic             ins_v;

    always_comb begin
        kill_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            kill_mask[k] = kill_valid && (k < int'(kill_count));
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NCHK; k++) begin
            if (sb_v[k] && (sb_rd[k] != 5'd0) &&
                ((issue_use1 && (sb_rd[k] == issue_rs1)) ||
                 (issue_use2 && (sb_rd[k] == issue_rs2)))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && issue_valid;
    end

    // Handshake: an instruction transfers in any cycle where issue_valid and issue_ready
    // are both high; issue_ready never depends on issue_valid except through the hazard.
    assign issue_ready = !hazard && !kill_valid && !rst;
    assign issue_fire  = issue_valid && issue_ready;
    assign stall_evt   = issue_valid && !issue_ready && !rst;
    assign ins_v       = issue_fire && issue_werf && (issue_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_rd[k] <= 5'd0;
            end
        end else begin
            sb_v[0]  <= ins_v;
            sb_rd[0] <= ins_v ? issue_rd : 5'd0;
            // Kill is applied to the source entry before it moves one stage older.
            for (int k = 1; k < DEPTH; k++) begin
                sb_v[k]  <= sb_v[k-1] && !kill_mask[k-1];
                sb_rd[k] <= sb_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (issue_fire && (issue_cnt != {CNT_W{1'b1}})) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sb_v[k]) begin
                busy_mask[sb_rd[k]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    assign wb_valid = sb_v[DEPTH-1];
    assign wb_rd    = sb_v[DEPTH-1] ? sb_rd[DEPTH-1] : 5'd0;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Hazard controller for the in-order RISC-V pipeline. It sits between decode and execute and decides, each cycle, whether the decoded instruction may issue.
- Tracks in-flight register writes in a shift-register scoreboard that mirrors the decode→writeback delay line. Stalls issue on RAW hazards and squashes the youngest in-flight writes when a taken branch/jump is resolved.
- Replaces the fixed one-issue-per-5-cycles fetch throttle. Exports stall/issue performance counters.

Parameters:
- DEPTH, 3, stages between issue and register-file write (entry DEPTH-1 is writing back this cycle).
- WB_BYPASS, 0, 1 = regfile write-then-read in the same cycle is safe, so the writeback entry is excluded from the hazard check.
- CNT_W, 32, width of the performance counters.
- KW, 2, width of kill_count; must satisfy 2^KW > DEPTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode holds a valid instruction
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_use1  in  1  instruction reads rs1
- issue_use2  in  1  instruction reads rs2
- issue_rd  in  5  destination register
- issue_werf  in  1  instruction writes the register file
- kill_valid  in  1  branch redirect this cycle
- kill_count  in  KW  number of youngest entries to squash
- issue_ready  out  1  no hazard and no kill (combinational)
- issue_fire  out  1  issue_valid & issue_ready (combinational)
- wb_valid  out  1  oldest entry is valid and writing this cycle
- wb_rd  out  5  register written this cycle (0 when wb_valid=0)
- busy_mask  out  32  OR of valid scoreboard rd bits; bit 0 always 0
- stall_cnt  out  CNT_W  cycles with issue_valid & !issue_ready (saturating)
- issue_cnt  out  CNT_W  issued instructions (saturating)

Behaviour:
- State: sb[0..DEPTH-1], each entry holding {v, rd}. sb[0] is the youngest.
- Reset: all sb.v=0, sb.rd=0, stall_cnt=0, issue_cnt=0. Hence wb_valid=0, wb_rd=0, busy_mask=0.
- Outputs in reset cycle: issue_ready=0 and issue_fire=0 while rst=1.
- Hazard check:
  - Considers entries k = 0..DEPTH-1 when WB_BYPASS=0, and k = 0..DEPTH-2 when WB_BYPASS=1.
  - hazard = issue_valid & OR over those k of [ sb[k].v & sb[k].rd≠0 & ((issue_use1 & sb[k].rd==issue_rs1) | (issue_use2 & sb[k].rd==issue_rs2)) ].
- Issue: issue_ready = !hazard & !kill_valid & !rst.
- Kill (applied before the shift):
  - Entries sb[0..kill_count-1] have v cleared.
  - kill_count ≥ DEPTH clears all entries.
  - kill_count=0 with kill_valid=1 squashes only the issue slot.
- Shift, every cycle with no enable: sb[k] ← sb[k-1] post-kill for k≥1.
- Insert: sb[0] ← {issue_fire & issue_werf & issue_rd≠0, issue_rd}; otherwise a bubble {0, 0}.
- Writeback view: wb_valid = sb[DEPTH-1].v. wb_rd = sb[DEPTH-1].v ? sb[DEPTH-1].rd : 0.
- Latency: an issued write becomes visible in wb_* exactly DEPTH cycles after its issue cycle.
- RAW stall length for an immediately dependent instruction: DEPTH cycles if WB_BYPASS=0, DEPTH-1 cycles if WB_BYPASS=1.
- Register 0: rd=0 is never tracked, and rs=0 never hazards.
- Counters:
  - stall_cnt += 1 when issue_valid & !issue_ready & !rst.
  - issue_cnt += 1 on issue_fire.
  - Both hold at 2^CNT_W−1 (no wrap).
- Simultaneous events:
  - kill and hazard together: kill wins, still no fire, and the cycle counts as a stall.
  - kill and a fire request: no fire.
  - rst overrides everything, including an in-flight scoreboard (all entries dropped next cycle).

Test Plan:
- DEPTH=3, WB_BYPASS=0: issue rd=5 at c0, then hold rs1=5/use1=1 from c1 → issue_ready=0 c1–c3, fire at c4, stall_cnt=3, wb_valid=1 & wb_rd=5 in c3.
- Same sequence with WB_BYPASS=1 → stall c1–c2, fire at c3, stall_cnt=2.
- Issue rd=0, then an instruction reading rs1=0 → no stall, busy_mask=0x00000000, issue_cnt=2.
- Issue rd=7 at c0 and rd=8 at c1; at c2 assert kill_valid with kill_count=1 → no fire c2, busy_mask=0x00000080 after c2, wb_rd=7 in c3, rd=8 never appears on wb_*.
- Fill the scoreboard with rd=1,2,3, then assert rst for one cycle → next cycle busy_mask=0, wb_valid=0, both counters 0, dependent instruction on rs1=1 fires immediately.
- CNT_W=4: hold a 20-cycle hazard (feed rd=9 each time it retires, dependent on rs1=9) → stall_cnt saturates at 15 and stays there.
